// File: rtl/branch_pc_unit.sv
// Fetch PC register with branch/jump target resolution, stall-deferred redirect
// and saturating branch statistics.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 BranchValid,
  input  logic                 BranchTaken,
  input  logic                 JumpValid,
  input  logic [31:0]          ResolvePCPlus4,
  input  logic [31:0]          ShiftedOffset,
  input  logic [25:0]          JumpIndex,
  output logic [31:0]          PC,
  output logic [31:0]          PCPlus4,
  output logic                 Redirect,
  output logic                 PendingRedirect,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] TakenCount
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          pend_q, pend_d;
  logic                 redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  logic [31:0] branch_target_s;
  logic [31:0] jump_target_s;
  logic [31:0] req_target_s;
  logic [31:0] pc_plus4_s;
  logic        req_s;
  logic        accept_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Target arithmetic; a jump overrides a simultaneous taken branch.
  always_comb begin
    branch_target_s = ResolvePCPlus4 + ShiftedOffset;
    jump_target_s   = {ResolvePCPlus4[31:28], JumpIndex, 2'b00};
    req_s           = JumpValid | (BranchValid & BranchTaken);
    if (JumpValid) begin
      req_target_s = jump_target_s;
    end else begin
      req_target_s = branch_target_s;
    end
    pc_plus4_s = pc_q + 32'd4;
  end

  // PC sequencing: redirect, defer into HOLD while stalled, or fall through.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    redirect_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req_s) begin
          if (!Stall) begin
            pc_d       = req_target_s;
            redirect_d = 1'b1;
          end else begin
            pend_d  = req_target_s;
            state_d = ST_HOLD;
          end
        end else if (!Stall) begin
          pc_d = pc_plus4_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HOLD: begin
        // Anything resolving here is younger than the held redirect and is dropped.
        if (!Stall) begin
          pc_d       = pend_q;
          redirect_d = 1'b1;
          state_d    = ST_RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Statistics: only branches resolved in RUN count, stalled or not.
  always_comb begin
    accept_s     = BranchValid & (state_q == ST_RUN);
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (accept_s) begin
      branch_cnt_d = sat_inc(branch_cnt_q);
      if (BranchTaken) begin
        taken_cnt_d = sat_inc(taken_cnt_q);
      end else begin
        taken_cnt_d = taken_cnt_q;
      end
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
  end

  // State register bank.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      pend_q       <= 32'h0000_0000;
      redirect_q   <= 1'b0;
      branch_cnt_q <= CNT_ZERO;
      taken_cnt_q  <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      redirect_q   <= redirect_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign PC              = pc_q;
  assign PCPlus4         = pc_plus4_s;
  assign Redirect        = redirect_q;
  assign PendingRedirect = (state_q == ST_HOLD);
  assign BranchCount     = branch_cnt_q;
  assign TakenCount      = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with an arithmetic reference model checked
// every cycle, plus literal expectations from the test plan.
module tb_branch_pc_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall, BranchValid, BranchTaken, JumpValid;
  logic [31:0] ResolvePCPlus4, ShiftedOffset;
  logic [25:0] JumpIndex;

  logic [31:0] pc, pc4, pc_b, pc4_b;
  logic        redir, pend, redir_b, pend_b;
  logic [15:0] bc, tc;
  logic [3:0]  bc4, tc4;

  int checks = 0;
  int failures = 0;

  branch_pc_unit dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchValid(BranchValid),
    .BranchTaken(BranchTaken), .JumpValid(JumpValid),
    .ResolvePCPlus4(ResolvePCPlus4), .ShiftedOffset(ShiftedOffset),
    .JumpIndex(JumpIndex), .PC(pc), .PCPlus4(pc4), .Redirect(redir),
    .PendingRedirect(pend), .BranchCount(bc), .TakenCount(tc)
  );

  branch_pc_unit #(.CNT_WIDTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchValid(BranchValid),
    .BranchTaken(BranchTaken), .JumpValid(JumpValid),
    .ResolvePCPlus4(ResolvePCPlus4), .ShiftedOffset(ShiftedOffset),
    .JumpIndex(JumpIndex), .PC(pc_b), .PCPlus4(pc4_b), .Redirect(redir_b),
    .PendingRedirect(pend_b), .BranchCount(bc4), .TakenCount(tc4)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: architectural PC, optional held target, raw branch tallies.
  logic [31:0] m_pc;
  logic [31:0] m_pend_tgt;
  bit          m_hold;
  bit          m_redirect;
  int          m_bc, m_tc;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_pc = 32'h0; m_pend_tgt = 32'h0; m_hold = 0; m_redirect = 0; m_bc = 0; m_tc = 0;
    end else begin
      bit          req;
      logic [31:0] tgt;
      m_redirect = 0;
      if (m_hold) begin
        if (!Stall) begin
          m_pc = m_pend_tgt; m_hold = 0; m_redirect = 1;
        end
      end else begin
        if (BranchValid) begin
          m_bc++;
          if (BranchTaken) m_tc++;
        end
        req = JumpValid || (BranchValid && BranchTaken);
        if (JumpValid) tgt = (ResolvePCPlus4 & 32'hF000_0000) | ({6'd0, JumpIndex} << 2);
        else           tgt = ResolvePCPlus4 + ShiftedOffset;
        if (req && !Stall)  begin m_pc = tgt; m_redirect = 1; end
        else if (req)       begin m_hold = 1; m_pend_tgt = tgt; end
        else if (!Stall)    m_pc = m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge Clk) begin
    if (!Reset) begin
      chk("m_pc",       pc,  m_pc);
      chk("m_pcplus4",  pc4, m_pc + 32'd4);
      chk("m_redirect", {31'd0, redir}, {31'd0, m_redirect});
      chk("m_pending",  {31'd0, pend},  {31'd0, m_hold});
      chk("m_bcount",   32'(bc),  (m_bc > 65535) ? 32'd65535 : 32'(m_bc));
      chk("m_tcount",   32'(tc),  (m_tc > 65535) ? 32'd65535 : 32'(m_tc));
      chk("m_bcount4",  32'(bc4), (m_bc > 15) ? 32'd15 : 32'(m_bc));
      chk("m_tcount4",  32'(tc4), (m_tc > 15) ? 32'd15 : 32'(m_tc));
      chk("m_pc_w4",    pc_b, m_pc);
    end
  end

  task automatic idle();
    Stall = 0; BranchValid = 0; BranchTaken = 0; JumpValid = 0;
    ResolvePCPlus4 = 32'h0; ShiftedOffset = 32'h0; JumpIndex = 26'h0;
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  initial begin
    idle();
    repeat (2) @(negedge Clk);
    Reset = 0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h4);
    chk("rst_redirect", {31'd0, redir}, 32'd0);
    chk("rst_bc", 32'(bc), 32'd0);

    // Sequential fetch
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_pc", pc, 32'(i * 4));
      chk("seq_redirect", {31'd0, redir}, 32'd0);
    end

    // Taken backward branch, then not-taken
    BranchValid = 1; BranchTaken = 1; ResolvePCPlus4 = 32'h104; ShiftedOffset = 32'hFFFF_FFF0;
    tick();
    chk("bt_pc", pc, 32'hF4);
    chk("bt_redirect", {31'd0, redir}, 32'd1);
    chk("bt_bc", 32'(bc), 32'd1);
    chk("bt_tc", 32'(tc), 32'd1);
    idle();
    tick();
    chk("bt_pulse_end", {31'd0, redir}, 32'd0);
    chk("bt_fall_pc", pc, 32'hF8);
    BranchValid = 1; BranchTaken = 0; ResolvePCPlus4 = 32'h104; ShiftedOffset = 32'hFFFF_FFF0;
    tick();
    chk("bnt_pc", pc, 32'hFC);
    chk("bnt_bc", 32'(bc), 32'd2);
    chk("bnt_tc", 32'(tc), 32'd1);

    // Stalled jump deferred through HOLD; branches in HOLD ignored
    idle();
    Stall = 1; JumpValid = 1; ResolvePCPlus4 = 32'h4000_0010; JumpIndex = 26'h100;
    tick();
    chk("sj_pc_hold", pc, 32'hFC);
    chk("sj_pending", {31'd0, pend}, 32'd1);
    chk("sj_redirect", {31'd0, redir}, 32'd0);
    idle();
    Stall = 1; BranchValid = 1; BranchTaken = 1; ResolvePCPlus4 = 32'h500; ShiftedOffset = 32'h8;
    tick();
    tick();
    chk("sj_hold_pc", pc, 32'hFC);
    chk("sj_hold_bc", 32'(bc), 32'd2);
    chk("sj_hold_tc", 32'(tc), 32'd1);
    Stall = 0;
    tick();
    chk("sj_exit_pc", pc, 32'h4000_0400);
    chk("sj_exit_redirect", {31'd0, redir}, 32'd1);
    chk("sj_exit_pending", {31'd0, pend}, 32'd0);
    chk("sj_exit_bc", 32'(bc), 32'd2);

    // Simultaneous jump and taken branch
    idle();
    JumpValid = 1; JumpIndex = 26'h10; BranchValid = 1; BranchTaken = 1;
    ResolvePCPlus4 = 32'h8; ShiftedOffset = 32'h20;
    tick();
    chk("jb_pc", pc, 32'h40);
    chk("jb_bc", 32'(bc), 32'd3);
    chk("jb_tc", 32'(tc), 32'd2);
    chk("jb_redirect", {31'd0, redir}, 32'd1);

    // Asynchronous reset between edges
    idle();
    #2 Reset = 1;
    #1;
    chk("ar_pc", pc, 32'h0);
    chk("ar_pc4", pc4, 32'h4);
    chk("ar_bc", 32'(bc), 32'd0);
    chk("ar_tc", 32'(tc), 32'd0);
    chk("ar_redirect", {31'd0, redir}, 32'd0);
    tick();
    Reset = 0;
    tick();
    chk("rel_pc", pc, 32'h4);

    // Reset during HOLD discards the held target
    Stall = 1; BranchValid = 1; BranchTaken = 1; ResolvePCPlus4 = 32'h200; ShiftedOffset = 32'h40;
    tick();
    chk("rh_pending", {31'd0, pend}, 32'd1);
    idle();
    Stall = 1;
    #2 Reset = 1;
    #1;
    chk("rh_pending_clr", {31'd0, pend}, 32'd0);
    tick();
    Reset = 0; Stall = 0;
    tick();
    chk("rh_pc", pc, 32'h4);
    chk("rh_redirect", {31'd0, redir}, 32'd0);

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      BranchValid = 1; BranchTaken = 1; ResolvePCPlus4 = 32'h100; ShiftedOffset = 32'h0;
      tick();
    end
    chk("sat_bc16", 32'(bc), 32'd20);
    chk("sat_tc16", 32'(tc), 32'd20);
    chk("sat_bc4", 32'(bc4), 32'd15);
    chk("sat_tc4", 32'(tc4), 32'd15);
    chk("sat_pc", pc, 32'h100);
    idle();
    Stall = 1; BranchValid = 1; BranchTaken = 0;
    tick();
    chk("stall_nt_bc", 32'(bc), 32'd21);
    chk("stall_nt_tc", 32'(tc), 32'd20);
    chk("stall_nt_pc", pc, 32'h100);
    chk("stall_nt_bc4", 32'(bc4), 32'd15);

    // PC wrap and branch-target carry discard
    idle();
    JumpValid = 1; ResolvePCPlus4 = 32'hF000_0000; JumpIndex = 26'h3FF_FFFF;
    tick();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    idle();
    tick();
    chk("wrap_next", pc, 32'h0);
    BranchValid = 1; BranchTaken = 1; ResolvePCPlus4 = 32'hFFFF_FFF0; ShiftedOffset = 32'h20;
    tick();
    chk("carry_pc", pc, 32'h10);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage that consumes the word-aligned branch offset produced by the left-shift-by-2 stage. It holds the fetch PC and computes the branch target (PC+4 + shifted offset) and the jump target. It redirects fetch on taken branches and jumps, and defers a redirect that arrives during a hazard stall. It also keeps saturating branch and taken-branch statistics counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_WIDTH, 16, width of each statistics counter
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hazard-unit stall; PC holds while high
- BranchValid  in  1  a conditional branch is resolved this cycle
- BranchTaken  in  1  branch outcome; qualified by BranchValid
- JumpValid  in  1  an unconditional jump is resolved this cycle
- ResolvePCPlus4  in  32  PC+4 of the resolving branch or jump
- ShiftedOffset  in  32  sign-extended immediate, already shifted left by 2
- JumpIndex  in  26  jump instruction index field
- PC  out  32  current fetch address (registered)
- PCPlus4  out  32  PC + 4 (combinational from PC)
- Redirect  out  1  registered one-cycle pulse after PC is loaded with a target; used to flush IF/ID
- PendingRedirect  out  1  high while a deferred redirect is held (HOLD state)
- BranchCount  out  CNT_WIDTH  accepted branches
- TakenCount  out  CNT_WIDTH  accepted taken branches

## Operation
- BranchTarget = ResolvePCPlus4 + ShiftedOffset, modulo 2^32. Carry-out is discarded.
- JumpTarget = {ResolvePCPlus4[31:28], JumpIndex, 2'b00}.
- A redirect request is JumpValid, or BranchValid && BranchTaken.
- If JumpValid and BranchValid are asserted together, the jump wins. The branch is still counted.
- State RUN (reset state):
  - Stall=0 with a request: PC <= target; Redirect <= 1.
  - Stall=0 without a request: PC <= PC+4. 0xFFFF_FFFC wraps to 0x0000_0000.
  - Stall=1 with a request: the target is captured in an internal pending register; PC holds; the state goes to HOLD.
  - Stall=1 without a request: PC holds.
- State HOLD:
  - PendingRedirect = 1.
  - Stall=1: PC holds.
  - Stall=0: PC <= pending target; Redirect <= 1; the state goes to RUN.
  - All BranchValid/JumpValid inputs are ignored in HOLD, including on the exit cycle. Those instructions are younger than the pending redirect and are flushed.
- Counters:
  - A branch is accepted when BranchValid=1 in RUN, whether or not Stall is high.
  - BranchCount increments on each accepted branch.
  - TakenCount increments on each accepted branch with BranchTaken=1.
  - Both counters saturate at all-ones. Jumps are not counted.
- Reset values:
  - PC = RESET_PC
  - PCPlus4 = RESET_PC+4
  - Redirect = 0
  - PendingRedirect = 0
  - BranchCount = TakenCount = 0
  - State = RUN; pending target = 0.
- Reset asserted mid-HOLD discards the pending redirect.

## Timing
- All inputs are sampled on the rising edge of Clk.
- Request to new PC: 1 cycle; the PC changes at the sampling edge.
- Redirect is high for exactly the cycle following the edge that loads a target, from either RUN or HOLD exit. Otherwise it is 0.
- A deferred redirect loads at the first edge with Stall=0. Total latency is 1 + the number of stalled edges after capture.
- PendingRedirect rises at the capture edge and falls at the load edge.
- Counters update at the sampling edge, so new values are visible the next cycle.
- Reset acts immediately and asynchronously on all registers. Release takes effect at the next rising edge: the first edge after release gives PC = RESET_PC+4 if Stall=0.
- No combinational path exists from inputs to any output; PCPlus4 depends only on PC.

## Test plan
- Reset mid-run: PC=0x40, BranchCount=3; assert Reset between edges -> PC=0x0 and counters 0 immediately, before the next edge.
- Sequential fetch: no requests, Stall=0, 4 edges -> PC=0x4, 0x8, 0xC, 0x10; Redirect stays 0.
- Taken backward branch: ResolvePCPlus4=0x104, ShiftedOffset=0xFFFF_FFF0, BranchValid=BranchTaken=1 -> next PC=0xF4, Redirect pulses 1 cycle, BranchCount=1, TakenCount=1. Repeat with BranchTaken=0 -> PC+4, BranchCount=2, TakenCount=1.
- Stalled jump: Stall=1, JumpValid=1, ResolvePCPlus4=0x4000_0010, JumpIndex=0x100 -> PC held, PendingRedirect=1. A taken branch presented during HOLD is ignored with counters unchanged. After 2 stalled edges, Stall=0 -> PC=0x4000_0400, Redirect pulses, PendingRedirect=0.
- Simultaneous jump + taken branch in RUN: JumpIndex=0x10, ResolvePCPlus4=0x0000_0008, ShiftedOffset=0x20 -> PC=0x40 (jump target, not 0x28), BranchCount and TakenCount each +1.
- Wrap and saturation: CNT_WIDTH=4, 20 accepted taken branches -> both counters hold at 15. PC=0xFFFF_FFFC with no request -> PC=0x0.
